bcd_display_fmt: RTL and testbench

//  Converts the 32-bit step counter from the busy-beaver engine to 8 packed BCD digits for the
//  max7219 display driver. Sits between the counter output and display_value.

---
 rtl/bcd_fmt_pkg.sv | 16 +
 rtl/bcd_add3.sv | 9 +
 rtl/bcd_display_fmt.sv | 132 +++++++++++++
 tb/tb_bcd_display_fmt.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_fmt_pkg.sv
// Shared types and constants for the BCD display formatter.
package bcd_fmt_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_COMMIT
    } fmt_state_t;

    // ceil(32 * log10(2)) digits, so a full 32-bit count never truncates internally
    localparam int INT_DIGITS = 10;

    localparam logic [3:0] DIGIT_BLANK = 4'hF;
    localparam logic [3:0] DIGIT_MAX   = 4'h9;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble per-nibble correction: values of 5 and above get 3 added before the shift.
module bcd_add3 (
    input  logic [3:0] nibble,
    output logic [3:0] corrected
);

    assign corrected = (nibble >= 4'd5) ? nibble + 4'd3 : nibble;

endmodule

// File: rtl/bcd_display_fmt.sv
// Throttled sequential binary-to-BCD converter for the max7219 display path.
// Define BCD_LEADING_ZERO_BLANK_EN to commit leading zero digits as code-B blanks.
module bcd_display_fmt
    import bcd_fmt_pkg::*;
#(
    parameter int BIN_W          = 32,
    parameter int DIGITS         = 8,
    parameter int REFRESH_CYCLES = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [BIN_W-1:0]      bin_value,
    input  logic                  load,
    output logic [4*DIGITS-1:0]   bcd_value,
    output logic                  valid,
    output logic                  update,
    output logic                  overflow,
    output logic                  busy
);

    localparam int SCR_W = 4 * INT_DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    fmt_state_t               state;
    logic [BIN_W-1:0]         shreg;
    logic [SCR_W-1:0]         scratch;
    logic [SCR_W-1:0]         corrected;
    logic [CNT_W-1:0]         bit_cnt;
    logic [31:0]              refresh_cnt;
    logic                     pending;
    logic                     refresh_hit;
    logic                     capture;
    logic                     sat;
    logic [4*DIGITS-1:0]      formatted;

    for (genvar g = 0; g < INT_DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .nibble    (scratch[4*g +: 4]),
            .corrected (corrected[4*g +: 4])
        );
    end

    assign refresh_hit = (REFRESH_CYCLES == 0) || (refresh_cnt == 32'(REFRESH_CYCLES - 1));
    assign capture     = load || pending || refresh_hit;

    // Saturation and optional blanking are resolved on the finished scratch before commit.
    always_comb begin
`ifdef BCD_LEADING_ZERO_BLANK_EN
        logic lead;
`endif
        sat       = 1'b0;
        formatted = scratch[4*DIGITS-1:0];
        for (int i = DIGITS; i < INT_DIGITS; i++) begin
            if (scratch[4*i +: 4] != 4'd0) begin
                sat = 1'b1;
            end
        end
`ifdef BCD_LEADING_ZERO_BLANK_EN
        lead = 1'b1;
        for (int i = DIGITS - 1; i > 0; i--) begin
            if (scratch[4*i +: 4] != 4'd0) begin
                lead = 1'b0;
            end
            if (lead) begin
                formatted[4*i +: 4] = DIGIT_BLANK;
            end
        end
`endif
        if (sat) begin
            formatted = {DIGITS{DIGIT_MAX}};
        end
    end

    // SHIFT spends one extra cycle after the last shift so the commit lands BIN_W+2 edges after capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            shreg       <= '0;
            scratch     <= '0;
            bit_cnt     <= '0;
            refresh_cnt <= '0;
            pending     <= 1'b0;
            bcd_value   <= '0;
            valid       <= 1'b0;
            update      <= 1'b0;
            overflow    <= 1'b0;
            busy        <= 1'b0;
        end else begin
            update <= 1'b0;
            busy   <= (state != S_IDLE);
            case (state)
                S_IDLE: begin
                    if (capture) begin
                        shreg       <= bin_value;
                        scratch     <= '0;
                        bit_cnt     <= '0;
                        refresh_cnt <= '0;
                        pending     <= 1'b0;
                        state       <= S_SHIFT;
                    end else begin
                        refresh_cnt <= refresh_cnt + 32'd1;
                    end
                end
                S_SHIFT: begin
                    if (load) begin
                        pending <= 1'b1;
                    end
                    if (bit_cnt == CNT_W'(BIN_W)) begin
                        state <= S_COMMIT;
                    end else begin
                        {scratch, shreg} <= {corrected[SCR_W-2:0], shreg, 1'b0};
                        bit_cnt          <= bit_cnt + 1'b1;
                    end
                end
                S_COMMIT: begin
                    if (load) begin
                        pending <= 1'b1;
                    end
                    bcd_value <= formatted;
                    overflow  <= sat;
                    update    <= 1'b1;
                    valid     <= 1'b1;
                    state     <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_display_fmt.sv
// Scoreboard testbench for bcd_display_fmt (REFRESH_CYCLES=4); follows BCD_LEADING_ZERO_BLANK_EN.
module tb_bcd_display_fmt;

    localparam int LAT = 34;

    logic        clk;
    logic        rst;
    logic [31:0] bin_value;
    logic        load;
    logic [31:0] bcd_value;
    logic        valid;
    logic        update;
    logic        overflow;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    logic [32:0] exp_q[$];

    bcd_display_fmt #(
        .BIN_W          (32),
        .DIGITS         (8),
        .REFRESH_CYCLES (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bin_value (bin_value),
        .load      (load),
        .bcd_value (bcd_value),
        .valid     (valid),
        .update    (update),
        .overflow  (overflow),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference by decimal division: returns {overflow, bcd}.
    function automatic logic [32:0] model(input logic [31:0] v);
        logic [31:0] r;
        logic [3:0]  d[8];
        longint      rem;
        int          msd;
        if (v > 32'd99999999) begin
            return {1'b1, 32'h99999999};
        end
        rem = longint'(v);
        msd = 0;
        for (int i = 0; i < 8; i++) begin
            d[i] = 4'(rem % 10);
            rem  = rem / 10;
            if (d[i] != 4'd0) msd = i;
        end
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = d[i];
        end
`ifdef BCD_LEADING_ZERO_BLANK_EN
        for (int i = 1; i < 8; i++) begin
            if (i > msd) r[4*i +: 4] = 4'hF;
        end
`endif
        return {1'b0, r};
    endfunction

    task automatic start_conv(input logic [31:0] v);
        bin_value = v;
        load      = 1'b1;
        exp_q.push_back(model(v));
    endtask

    task automatic wait_update(output int cycles, output int busy_low);
        cycles   = 0;
        busy_low = 0;
        do begin
            @(posedge clk);
            @(negedge clk);
            load = 1'b0;
            cycles++;
            if (!busy) busy_low++;
        end while (!update && cycles < 200);
    endtask

    task automatic test_reset();
        int cyc, blo;
        logic [32:0] e;
        rst = 1'b1; load = 1'b0; bin_value = 32'd0;
        repeat (2) @(negedge clk);
        checks++; if (bcd_value !== 32'd0) begin failures++; $display("[TB] FAIL reset_bcd got %h want 0", bcd_value); end
        checks++; if (valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid got %b want 0", valid); end
        checks++; if (update !== 1'b0) begin failures++; $display("[TB] FAIL reset_update got %b want 0", update); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("[TB] FAIL reset_overflow got %b want 0", overflow); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
        exp_q.push_back(model(32'd0));
        rst = 1'b0;
        wait_update(cyc, blo);
        e = exp_q.pop_front();
        checks++; if (cyc !== 4 + LAT) begin failures++; $display("[TB] FAIL auto_latency got %0d want %0d", cyc, 4 + LAT); end
        checks++; if (blo !== 4) begin failures++; $display("[TB] FAIL auto_busy_low got %0d want 4", blo); end
        checks++; if (bcd_value !== e[31:0]) begin failures++; $display("[TB] FAIL auto_zero got %h want %h", bcd_value, e[31:0]); end
        checks++; if (valid !== 1'b1) begin failures++; $display("[TB] FAIL auto_valid got %b want 1", valid); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("[TB] FAIL auto_overflow got %b want 0", overflow); end
    endtask

    task automatic test_basic();
        int cyc, blo;
        logic [32:0] e;
        start_conv(32'd12345678);
        wait_update(cyc, blo);
        e = exp_q.pop_front();
        checks++; if (cyc !== LAT + 1) begin failures++; $display("[TB] FAIL basic_latency got %0d want %0d", cyc, LAT + 1); end
        checks++; if (blo !== 1) begin failures++; $display("[TB] FAIL basic_busy_low got %0d want 1", blo); end
        checks++; if (bcd_value !== e[31:0]) begin failures++; $display("[TB] FAIL basic_value got %h want %h", bcd_value, e[31:0]); end
        checks++; if (bcd_value !== 32'h12345678) begin failures++; $display("[TB] FAIL basic_const got %h want 12345678", bcd_value); end
        checks++; if (overflow !== e[32]) begin failures++; $display("[TB] FAIL basic_overflow got %b want %b", overflow, e[32]); end
        @(posedge clk);
        @(negedge clk);
        checks++; if (update !== 1'b0) begin failures++; $display("[TB] FAIL basic_update_width got %b want 0", update); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL basic_busy_end got %b want 0", busy); end
        checks++; if (bcd_value !== e[31:0]) begin failures++; $display("[TB] FAIL basic_hold got %h want %h", bcd_value, e[31:0]); end
    endtask

    task automatic test_saturate();
        logic [31:0] vals[3];
        int cyc, blo;
        logic [32:0] e;
        vals[0] = 32'd99999999;
        vals[1] = 32'd100000000;
        vals[2] = 32'hFFFFFFFF;
        for (int i = 0; i < 3; i++) begin
            start_conv(vals[i]);
            wait_update(cyc, blo);
            e = exp_q.pop_front();
            checks++; if (cyc !== LAT + 1) begin failures++; $display("[TB] FAIL sat_latency[%0d] got %0d want %0d", i, cyc, LAT + 1); end
            checks++; if (bcd_value !== e[31:0]) begin failures++; $display("[TB] FAIL sat_value[%0d] got %h want %h", i, bcd_value, e[31:0]); end
            checks++; if (overflow !== e[32]) begin failures++; $display("[TB] FAIL sat_overflow[%0d] got %b want %b", i, overflow, e[32]); end
        end
    endtask

    task automatic test_back_to_back();
        int first_k, second_k;
        logic [32:0] e;
        first_k  = 0;
        second_k = 0;
        start_conv(32'd7);
        for (int k = 1; k <= 80 && second_k == 0; k++) begin
            @(posedge clk);
            @(negedge clk);
            load = (k == 10);
            if (k == 20) begin
                bin_value = 32'd55;
                exp_q.push_back(model(32'd55));
            end
            if (update) begin
                e = exp_q.pop_front();
                checks++; if (bcd_value !== e[31:0]) begin failures++; $display("[TB] FAIL b2b_value k=%0d got %h want %h", k, bcd_value, e[31:0]); end
                if (first_k == 0) first_k = k;
                else second_k = k;
            end
        end
        load = 1'b0;
        checks++; if (first_k !== LAT + 1) begin failures++; $display("[TB] FAIL b2b_first_edge got %0d want %0d", first_k, LAT + 1); end
        checks++; if (second_k !== 2 * LAT + 2) begin failures++; $display("[TB] FAIL b2b_second_edge got %0d want %0d", second_k, 2 * LAT + 2); end
    endtask

    task automatic test_reset_mid();
        int cyc, blo, early;
        logic [32:0] e;
        early     = 0;
        bin_value = 32'd87654321;
        load      = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            @(posedge clk);
            @(negedge clk);
            load = 1'b0;
            if (update) early++;
        end
        rst = 1'b1;
        #1;
        checks++; if (bcd_value !== 32'd0) begin failures++; $display("[TB] FAIL mid_bcd got %h want 0", bcd_value); end
        checks++; if ({valid, update, overflow, busy} !== 4'b0) begin failures++; $display("[TB] FAIL mid_flags got %b want 0000", {valid, update, overflow, busy}); end
        checks++; if (early !== 0) begin failures++; $display("[TB] FAIL mid_early_update got %0d want 0", early); end
        @(negedge clk);
        rst = 1'b0;
        start_conv(32'd4096);
        wait_update(cyc, blo);
        e = exp_q.pop_front();
        checks++; if (cyc !== LAT + 1) begin failures++; $display("[TB] FAIL mid_latency got %0d want %0d", cyc, LAT + 1); end
        checks++; if (bcd_value !== e[31:0]) begin failures++; $display("[TB] FAIL mid_value got %h want %h", bcd_value, e[31:0]); end
        checks++; if (valid !== 1'b1) begin failures++; $display("[TB] FAIL mid_valid got %b want 1", valid); end
    endtask

    task automatic test_blank();
        logic [31:0] vals[4];
        int cyc, blo;
        logic [32:0] e;
        vals[0] = 32'd42;
        vals[1] = 32'd10000000;
        vals[2] = 32'd0;
        vals[3] = 32'd900;
        for (int i = 0; i < 4; i++) begin
            start_conv(vals[i]);
            wait_update(cyc, blo);
            e = exp_q.pop_front();
            checks++; if (bcd_value !== e[31:0]) begin failures++; $display("[TB] FAIL blank_value[%0d] got %h want %h", i, bcd_value, e[31:0]); end
            checks++; if (overflow !== e[32]) begin failures++; $display("[TB] FAIL blank_overflow[%0d] got %b want %b", i, overflow, e[32]); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturate();
        test_back_to_back();
        test_reset_mid();
        test_blank();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
